// File: rtl/wide_add_seq.sv
// Multi-cycle wide adder: streams 10-bit slices through a Ling/Knowles core.
// Optional subtract path enabled by defining WIDE_ADD_SUB_EN.
module adder (
    input  logic [9:0] a,
    input  logic [9:0] b,
    input  logic       cin,
    output logic [9:0] sum,
    output logic       cout
);
    logic [9:0]       g;
    logic [9:0]       t;
    logic [9:0]       p;
    logic [4:0][9:0]  gg;
    logic [4:0][9:0]  pp;
    logic [10:1]      h;
    logic [10:0]      c;

    assign g = a & b;
    assign t = a | b;
    assign p = a ^ b;

    // Ling recurrence h[i+1] = g[i] | t[i-1] & h[i]; carry-in acts as h[0]
    assign gg[0] = g;
    assign pp[0] = {t[8:0], 1'b1};

    for (genvar lv = 0; lv < 4; lv++) begin : g_lv
        for (genvar i = 0; i < 10; i++) begin : g_bit
            if (i >= (1 << lv)) begin : g_op
                assign gg[lv+1][i] = gg[lv][i]
                                   | (pp[lv][i] & gg[lv][i-(1<<lv)]);
                assign pp[lv+1][i] = pp[lv][i] & pp[lv][i-(1<<lv)];
            end else begin : g_pass
                assign gg[lv+1][i] = gg[lv][i];
                assign pp[lv+1][i] = pp[lv][i];
            end
        end
    end

    assign c[0] = cin;
    for (genvar i = 0; i < 10; i++) begin : g_car
        assign h[i+1] = gg[4][i] | (pp[4][i] & cin);
        assign c[i+1] = t[i] & h[i+1];
    end

    assign sum  = p ^ c[9:0];
    assign cout = c[10];
endmodule

module wide_add_seq #(
    parameter int NWORDS = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [10*NWORDS-1:0] in_a,
    input  logic [10*NWORDS-1:0] in_b,
    input  logic                 in_cin,
`ifdef WIDE_ADD_SUB_EN
    input  logic                 in_sub,
`endif
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [10*NWORDS-1:0] out_sum,
    output logic                 out_cout,
    output logic                 out_ovf
);
    localparam int W  = 10 * NWORDS;
    localparam int IW = (NWORDS > 1) ? $clog2(NWORDS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [W-1:0]    a_r;
    logic [W-1:0]    b_r;
    logic [W-1:0]    sum_r;
    logic            carry_r;
    logic [IW-1:0]   idx;
    logic            last;
    logic            accept;
    logic [9:0]      sl_a;
    logic [9:0]      sl_b;
    logic [9:0]      sl_s;
    logic            sl_co;
    logic [W-1:0]    b_load;
    logic            c_load;

    assign last   = (idx == IW'(NWORDS - 1));
    assign accept = (state == IDLE) && in_valid;
    assign sl_a   = a_r[10*int'(idx) +: 10];
    assign sl_b   = b_r[10*int'(idx) +: 10];

`ifdef WIDE_ADD_SUB_EN
    assign b_load = in_sub ? ~in_b : in_b;
    assign c_load = in_sub ? 1'b1 : in_cin;
`else
    assign b_load = in_b;
    assign c_load = in_cin;
`endif

    adder u_core (
        .a    (sl_a),
        .b    (sl_b),
        .cin  (carry_r),
        .sum  (sl_s),
        .cout (sl_co)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (in_valid)  state_nx = RUN;
            RUN:  if (last)      state_nx = DONE;
            DONE: if (out_ready) state_nx = IDLE;
            default:             state_nx = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_ovf   = 1'b0;
        unique case (state)
            IDLE: in_ready = 1'b1;
            RUN:  in_ready = 1'b0;
            DONE: begin
                out_valid = 1'b1;
                out_ovf   = (a_r[W-1] ~^ b_r[W-1])
                          & (sum_r[W-1] ^ a_r[W-1]);
            end
            default: in_ready = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r     <= '0;
            b_r     <= '0;
            sum_r   <= '0;
            carry_r <= 1'b0;
            idx     <= '0;
        end else if (accept) begin
            a_r     <= in_a;
            b_r     <= b_load;
            carry_r <= c_load;
            idx     <= '0;
        end else if (state == RUN) begin
            sum_r[10*int'(idx) +: 10] <= sl_s;
            carry_r <= sl_co;
            if (!last) begin
                idx <= idx + 1'b1;
            end
        end
    end

    assign out_sum  = sum_r;
    assign out_cout = carry_r;
endmodule
